sram_like_bridge_ooo: RTL and testbench



---
 rtl/sram_like_pkg.sv | 51 +++++
 rtl/sram_like_outstanding_ctr.sv | 39 +++
 rtl/sram_like_bridge_ooo.sv | 115 +++++++++++
 tb/tb_sram_like_bridge_ooo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// rtl/sram_like_pkg.sv - size codes, bridge states and byte-enable decoding
package sram_like_pkg;

  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;
  localparam logic [2:0] SZ_DWORD = 3'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] cnt;
    logic [2:0] lo;
  } wen_info_t;

  // Legal byte enables form one contiguous run whose length is a power of two.
  function automatic wen_info_t wen_scan(input logic [7:0] wen, input int bytes);
    wen_info_t r;
    int cnt, lo, hi;
    cnt = 0;
    lo  = 0;
    hi  = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < bytes && wen[i]) begin
        if (cnt == 0) lo = i;
        hi = i;
        cnt++;
      end
    end
    r.legal = (cnt != 0) && (hi - lo + 1 == cnt) && ((cnt & (cnt - 1)) == 0);
    r.cnt   = 4'(cnt);
    r.lo    = 3'(lo);
    return r;
  endfunction

  function automatic logic [2:0] wen_to_size(input logic [7:0] wen, input int bytes);
    wen_info_t r;
    int n;
    r = wen_scan(wen, bytes);
    n = r.legal ? int'(r.cnt) : bytes;
    return (n >= 8) ? SZ_DWORD : (n >= 4) ? SZ_WORD : (n >= 2) ? SZ_HALF : SZ_BYTE;
  endfunction

  function automatic logic [2:0] wen_to_offset(input logic [7:0] wen, input int bytes);
    wen_info_t r;
    r = wen_scan(wen, bytes);
    return r.legal ? r.lo : 3'd0;
  endfunction

endpackage

// File: rtl/sram_like_outstanding_ctr.sv
// rtl/sram_like_outstanding_ctr.sv - in-flight count and responses ahead of the current op
module sram_like_outstanding_ctr #(
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_OUT) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic data_ok,
  input  logic load_older,
  output logic full,
  output logic older_zero
);

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] older;
  logic          dec;

  // A response with nothing in flight is a bus protocol error and is ignored.
  assign dec        = data_ok && (out_cnt != '0);
  assign full       = (out_cnt == CW'(MAX_OUT));
  assign older_zero = (older == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= '0;
      older   <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(accept) - CW'(dec);
      if (load_older) older <= out_cnt - CW'(dec);
      else if (data_ok && !older_zero) older <= older - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(data_ok && out_cnt == '0));
  end

endmodule

// File: rtl/sram_like_bridge_ooo.sv
// rtl/sram_like_bridge_ooo.sv - stall-based SRAM port to req/addr_ok/data_ok bus bridge
module sram_like_bridge_ooo
  import sram_like_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUT   = 4,
  parameter bit POSTED_WR = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [2:0]          cpu_size,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                data_req,
  output logic                data_wr,
  output logic [2:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W-1:0]   data_rdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  state_t              state;
  logic                drop;
  logic                l_wr;
  logic [2:0]          l_size;
  logic [ADDR_W-1:0]   l_addr;
  logic [DATA_W-1:0]   l_wdata;

  logic [7:0]          wen8;
  logic [2:0]          wen_off;
  logic                cur_wr;
  logic [2:0]          cur_size;
  logic [ADDR_W-1:0]   cur_addr;
  logic                is_idle, is_req, is_wait;
  logic                full, older_zero;
  logic                accept, own_ok, posted, retire, load_older;

  assign wen8     = 8'(cpu_wen);
  assign wen_off  = wen_to_offset(wen8, BYTES);
  assign cur_wr   = |cpu_wen;
  assign cur_size = cur_wr ? wen_to_size(wen8, BYTES) : cpu_size;
  assign cur_addr = cur_wr ? {cpu_addr[ADDR_W-1:OFF_W], wen_off[OFF_W-1:0]} : cpu_addr;

  assign is_idle = (state == IDLE);
  assign is_req  = (state == REQ);
  assign is_wait = (state == WAIT);

  // Once raised, a request stays up with frozen fields until accepted, flush or not.
  assign data_req   = is_req || (is_idle && cpu_en && !flush && !full);
  assign data_wr    = is_idle ? cur_wr    : l_wr;
  assign data_size  = is_idle ? cur_size  : l_size;
  assign data_addr  = is_idle ? cur_addr  : l_addr;
  assign data_wdata = is_idle ? cpu_wdata : l_wdata;

  assign accept     = data_req && data_addr_ok;
  assign own_ok     = is_wait && data_data_ok && older_zero;
  assign posted     = data_wr && POSTED_WR;
  assign load_older = accept && !posted && !flush && !(is_req && drop);
  assign retire     = (accept && posted && !flush && !(is_req && drop)) || (own_ok && !flush);
  assign cpu_stall  = cpu_en && !retire && !flush;
  assign cpu_rdata  = (own_ok && !flush && !l_wr) ? data_rdata : '0;

  sram_like_outstanding_ctr #(.MAX_OUT(MAX_OUT)) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .data_ok    (data_data_ok),
    .load_older (load_older),
    .full       (full),
    .older_zero (older_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      drop    <= 1'b0;
      l_wr    <= 1'b0;
      l_size  <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else begin
      if (is_idle && data_req) begin
        l_wr    <= cur_wr;
        l_size  <= cur_size;
        l_addr  <= cur_addr;
        l_wdata <= cpu_wdata;
      end
      case (state)
        IDLE: if (data_req) state <= load_older ? WAIT : (accept ? IDLE : REQ);
        REQ: begin
          if (accept) begin
            state <= load_older ? WAIT : IDLE;
            drop  <= 1'b0;
          end else if (flush) begin
            drop  <= 1'b1;
          end
        end
        WAIT: if (flush || own_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_bridge_ooo.sv
// tb/tb_sram_like_bridge_ooo.sv - directed bench for the SRAM-like bridge
module tb_sram_like_bridge_ooo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst, flush, cpu_en, cpu_stall, data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  cpu_wen;
  logic [2:0]  cpu_size, data_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, data_addr, data_wdata, data_rdata;

  logic        a_rst, a_flush, a_cpu_en, a_cpu_stall, a_data_req, a_data_wr, a_data_addr_ok, a_data_data_ok;
  logic [7:0]  a_cpu_wen;
  logic [2:0]  a_cpu_size, a_data_size;
  logic [31:0] a_cpu_addr, a_data_addr;
  logic [63:0] a_cpu_wdata, a_cpu_rdata, a_data_wdata, a_data_rdata;

  sram_like_bridge_ooo dut (
    .clk(clk), .rst(rst), .flush(flush), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_size(cpu_size), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  sram_like_bridge_ooo #(.DATA_W(64), .MAX_OUT(2)) alt (
    .clk(clk), .rst(a_rst), .flush(a_flush), .cpu_en(a_cpu_en), .cpu_wen(a_cpu_wen),
    .cpu_addr(a_cpu_addr), .cpu_size(a_cpu_size), .cpu_wdata(a_cpu_wdata), .cpu_rdata(a_cpu_rdata),
    .cpu_stall(a_cpu_stall), .data_req(a_data_req), .data_wr(a_data_wr), .data_size(a_data_size),
    .data_addr(a_data_addr), .data_wdata(a_data_wdata), .data_rdata(a_data_rdata),
    .data_addr_ok(a_data_addr_ok), .data_data_ok(a_data_data_ok)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush = 0; cpu_en = 0; cpu_wen = 0; cpu_addr = 0; cpu_size = 0; cpu_wdata = 0;
    data_rdata = 0; data_addr_ok = 0; data_data_ok = 0;
  endtask

  task automatic a_clr();
    a_flush = 0; a_cpu_en = 0; a_cpu_wen = 0; a_cpu_addr = 0; a_cpu_size = 0; a_cpu_wdata = 0;
    a_data_rdata = 0; a_data_addr_ok = 0; a_data_data_ok = 0;
  endtask

  task automatic test_reset();
    rst = 1; a_rst = 1; clr(); a_clr();
    cyc(); cyc();
    rst = 0; a_rst = 0;
    @(negedge clk);
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", data_req); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", cpu_stall); end
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h exp=0", cpu_rdata); end
    total++; if (a_data_req !== 1'b0) begin bad++; $display("FAIL rst_a_req got=%0h exp=0", a_data_req); end
    cyc();
  endtask

  task automatic test_read();
    cpu_en = 1; cpu_addr = 32'h42; cpu_size = 3'd1; data_addr_ok = 1;
    @(negedge clk);
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL rd_req0 got=%0h exp=1", data_req); end
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rd_stall0 got=%0h exp=1", cpu_stall); end
    total++; if (data_addr !== 32'h42) begin bad++; $display("FAIL rd_addr got=%0h exp=42", data_addr); end
    total++; if (data_size !== 3'd1) begin bad++; $display("FAIL rd_size got=%0h exp=1", data_size); end
    total++; if (data_wr !== 1'b0) begin bad++; $display("FAIL rd_wr got=%0h exp=0", data_wr); end
    cyc(); data_addr_ok = 0;
    @(negedge clk);
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL rd_req1 got=%0h exp=0", data_req); end
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rd_stall1 got=%0h exp=1", cpu_stall); end
    cyc(); data_data_ok = 1; data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rd_stall2 got=%0h exp=0", cpu_stall); end
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%0h exp=deadbeef", cpu_rdata); end
    cyc(); cpu_en = 0; data_data_ok = 0;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rd_data_after got=%0h exp=0", cpu_rdata); end
    cyc(); clr();
  endtask

  task automatic test_posted();
    cpu_en = 1; cpu_wen = 4'b1100; cpu_addr = 32'h100; cpu_wdata = 32'h12340000; data_addr_ok = 1;
    @(negedge clk);
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL pw_req got=%0h exp=1", data_req); end
    total++; if (data_wr !== 1'b1) begin bad++; $display("FAIL pw_wr got=%0h exp=1", data_wr); end
    total++; if (data_size !== 3'd1) begin bad++; $display("FAIL pw_size got=%0h exp=1", data_size); end
    total++; if (data_addr !== 32'h102) begin bad++; $display("FAIL pw_addr got=%0h exp=102", data_addr); end
    total++; if (data_wdata !== 32'h12340000) begin bad++; $display("FAIL pw_wdata got=%0h exp=12340000", data_wdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL pw_stall got=%0h exp=0", cpu_stall); end
    cyc(); cpu_wen = 0; cpu_addr = 32'h200; cpu_size = 3'd2;
    @(negedge clk);
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL pr_stall0 got=%0h exp=1", cpu_stall); end
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h55;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL pr_data1 got=%0h exp=0", cpu_rdata); end
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL pr_stall1 got=%0h exp=1", cpu_stall); end
    cyc(); data_rdata = 32'h66;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h66) begin bad++; $display("FAIL pr_data2 got=%0h exp=66", cpu_rdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL pr_stall2 got=%0h exp=0", cpu_stall); end
    cyc(); clr();
  endtask

  task automatic test_encode();
    cpu_en = 1; cpu_wen = 4'b0101; cpu_addr = 32'h13; data_addr_ok = 1;
    @(negedge clk);
    total++; if (data_size !== 3'd2) begin bad++; $display("FAIL enc_ill_size got=%0h exp=2", data_size); end
    total++; if (data_addr !== 32'h10) begin bad++; $display("FAIL enc_ill_addr got=%0h exp=10", data_addr); end
    cyc(); cpu_wen = 4'b1000; cpu_addr = 32'h20; data_data_ok = 1;
    @(negedge clk);
    total++; if (data_size !== 3'd0) begin bad++; $display("FAIL enc_b_size got=%0h exp=0", data_size); end
    total++; if (data_addr !== 32'h23) begin bad++; $display("FAIL enc_b_addr got=%0h exp=23", data_addr); end
    cyc(); cpu_en = 0; cpu_wen = 0; data_addr_ok = 0;
    @(negedge clk);
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL enc_idle_req got=%0h exp=0", data_req); end
    cyc(); clr();
  endtask

  task automatic test_req_hold();
    cpu_en = 1; cpu_addr = 32'h300; cpu_size = 3'd2;
    @(negedge clk);
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL hold_req0 got=%0h exp=1", data_req); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      cpu_addr = 32'h304 + 32'(4 * i);
      @(negedge clk);
      total++; if (data_req !== 1'b1) begin bad++; $display("FAIL hold_req%0d got=%0h exp=1", i + 1, data_req); end
      total++; if (data_addr !== 32'h300) begin bad++; $display("FAIL hold_addr%0d got=%0h exp=300", i + 1, data_addr); end
      cyc();
    end
    data_addr_ok = 1;
    @(negedge clk);
    total++; if (data_addr !== 32'h300) begin bad++; $display("FAIL hold_addr_acc got=%0h exp=300", data_addr); end
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h77;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h77) begin bad++; $display("FAIL hold_data got=%0h exp=77", cpu_rdata); end
    cyc(); clr();
  endtask

  task automatic test_flush_wait();
    cpu_en = 1; cpu_addr = 32'h400; cpu_size = 3'd2; data_addr_ok = 1;
    cyc(); data_addr_ok = 0; flush = 1;
    @(negedge clk);
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL fw_stall got=%0h exp=0", cpu_stall); end
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL fw_req got=%0h exp=0", data_req); end
    cyc(); flush = 0; cpu_addr = 32'h500; data_addr_ok = 1;
    @(negedge clk);
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL fw_new_req got=%0h exp=1", data_req); end
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h99;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL fw_drop got=%0h exp=0", cpu_rdata); end
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL fw_stall_old got=%0h exp=1", cpu_stall); end
    cyc(); data_rdata = 32'h11;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h11) begin bad++; $display("FAIL fw_data got=%0h exp=11", cpu_rdata); end
    cyc(); clr();
  endtask

  task automatic test_flush_req();
    cpu_en = 1; cpu_addr = 32'h600; cpu_size = 3'd2;
    cyc(); flush = 1;
    @(negedge clk);
    total++; if (data_req !== 1'b1) begin bad++; $display("FAIL fr_req got=%0h exp=1", data_req); end
    total++; if (data_addr !== 32'h600) begin bad++; $display("FAIL fr_addr got=%0h exp=600", data_addr); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL fr_stall got=%0h exp=0", cpu_stall); end
    cyc(); flush = 0; cpu_addr = 32'h700; data_addr_ok = 1;
    @(negedge clk);
    total++; if (data_addr !== 32'h600) begin bad++; $display("FAIL fr_drain_addr got=%0h exp=600", data_addr); end
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL fr_block got=%0h exp=1", cpu_stall); end
    cyc();
    @(negedge clk);
    total++; if (data_addr !== 32'h700) begin bad++; $display("FAIL fr_new_addr got=%0h exp=700", data_addr); end
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hAB;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL fr_drop got=%0h exp=0", cpu_rdata); end
    cyc(); data_rdata = 32'hCD;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'hCD) begin bad++; $display("FAIL fr_data got=%0h exp=cd", cpu_rdata); end
    cyc(); clr();
  endtask

  task automatic test_flush_own();
    cpu_en = 1; cpu_addr = 32'h800; cpu_size = 3'd2; data_addr_ok = 1;
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h5A; flush = 1;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL fo_rdata got=%0h exp=0", cpu_rdata); end
    cyc(); flush = 0; data_data_ok = 0; cpu_addr = 32'h900; data_addr_ok = 1;
    cyc(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h3C;
    @(negedge clk);
    total++; if (cpu_rdata !== 32'h3C) begin bad++; $display("FAIL fo_next got=%0h exp=3c", cpu_rdata); end
    cyc(); clr();
  endtask

  task automatic test_max_out();
    a_cpu_en = 1; a_cpu_wen = 8'hFF; a_cpu_addr = 32'h0; a_data_addr_ok = 1;
    @(negedge clk);
    total++; if (a_data_req !== 1'b1) begin bad++; $display("FAIL mo_req0 got=%0h exp=1", a_data_req); end
    cyc(); a_cpu_addr = 32'h8;
    @(negedge clk);
    total++; if (a_data_req !== 1'b1) begin bad++; $display("FAIL mo_req1 got=%0h exp=1", a_data_req); end
    cyc(); a_cpu_addr = 32'h10; a_cpu_wen = 8'h01;
    @(negedge clk);
    total++; if (a_data_req !== 1'b0) begin bad++; $display("FAIL mo_full_req got=%0h exp=0", a_data_req); end
    total++; if (a_cpu_stall !== 1'b1) begin bad++; $display("FAIL mo_full_stall got=%0h exp=1", a_cpu_stall); end
    cyc(); a_data_data_ok = 1;
    @(negedge clk);
    total++; if (a_data_req !== 1'b0) begin bad++; $display("FAIL mo_dok_req got=%0h exp=0", a_data_req); end
    cyc(); a_data_data_ok = 0;
    @(negedge clk);
    total++; if (a_data_req !== 1'b1) begin bad++; $display("FAIL mo_free_req got=%0h exp=1", a_data_req); end
    total++; if (a_cpu_stall !== 1'b0) begin bad++; $display("FAIL mo_free_stall got=%0h exp=0", a_cpu_stall); end
    cyc(); a_clr(); a_data_data_ok = 1;
    cyc(); cyc(); a_clr();
  endtask

  task automatic test_wide_reset();
    a_cpu_en = 1; a_cpu_wen = 8'hF0; a_cpu_addr = 32'h1000; a_cpu_wdata = 64'h1122334455667788;
    @(negedge clk);
    total++; if (a_data_size !== 3'd2) begin bad++; $display("FAIL w64_size got=%0h exp=2", a_data_size); end
    total++; if (a_data_addr !== 32'h1004) begin bad++; $display("FAIL w64_addr got=%0h exp=1004", a_data_addr); end
    cyc(); a_rst = 1;
    cyc(); a_rst = 0; a_clr();
    @(negedge clk);
    total++; if (a_data_req !== 1'b0) begin bad++; $display("FAIL mrst_req got=%0h exp=0", a_data_req); end
    total++; if (a_cpu_stall !== 1'b0) begin bad++; $display("FAIL mrst_stall got=%0h exp=0", a_cpu_stall); end
    total++; if (a_data_addr !== 32'h0) begin bad++; $display("FAIL mrst_addr got=%0h exp=0", a_data_addr); end
    total++; if (a_data_wr !== 1'b0) begin bad++; $display("FAIL mrst_wr got=%0h exp=0", a_data_wr); end
    total++; if (a_cpu_rdata !== 64'h0) begin bad++; $display("FAIL mrst_rdata got=%0h exp=0", a_cpu_rdata); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_read();
    test_posted();
    test_encode();
    test_req_hold();
    test_flush_wait();
    test_flush_req();
    test_flush_own();
    test_max_out();
    test_wide_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
